// File: rtl/gf180mcu_fd_io__seg_pwr_seq.sv
// Power, isolation and driver-enable sequencer for one pad-ring segment beyond a ring break.
// Power-up: switch on, wait for settled PGOOD, release isolation, enable drivers. Power-down reverses it.
module gf180mcu_fd_io__seg_pwr_seq #(
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned ISO_HOLD      = 8,
  parameter int unsigned TIMEOUT       = 1024,
  parameter int unsigned CNT_W         = 11
) (
  input  logic CLK,
  input  logic RST,
  input  logic REQ_ON,
  input  logic PGOOD,
  output logic PSW_EN,
  output logic ISO_EN,
  output logic DRV_EN,
  output logic ACK,
  output logic BUSY,
  output logic FAULT
);

  typedef enum logic [2:0] {
    S_OFF, S_PWR_UP, S_ISO_REL, S_ON, S_DRV_OFF, S_ISO_SET, S_PWR_DN, S_FLT
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(ISO_HOLD - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic             pgood_meta_q, pgood_s_q;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_OFF;
      pgood_meta_q <= 1'b0;
      pgood_s_q    <= 1'b0;
      dwell_q      <= '0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      pgood_meta_q <= PGOOD;
      pgood_s_q    <= pgood_meta_q;
      dwell_q      <= dwell_d;
      tmo_q        <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_OFF: begin
        if (REQ_ON) state_d = S_PWR_UP;
      end
      S_PWR_UP: begin
        // Settle count needs an unbroken run of good samples; the timeout keeps running through glitches.
        tmo_d   = tmo_q + 1'b1;
        dwell_d = pgood_s_q ? dwell_q + 1'b1 : '0;
        if (!REQ_ON)                                 state_d = S_PWR_DN;
        else if (pgood_s_q && dwell_q == SETTLE_LAST) state_d = S_ISO_REL;
        else if (tmo_q == TMO_LAST)                  state_d = S_FLT;
      end
      S_ISO_REL: begin
        dwell_d = dwell_q + 1'b1;
        if (!REQ_ON)                   state_d = S_ISO_SET;
        else if (dwell_q == HOLD_LAST) state_d = S_ON;
      end
      S_ON: begin
        if (!pgood_s_q)   state_d = S_FLT;
        else if (!REQ_ON) state_d = S_DRV_OFF;
      end
      S_DRV_OFF: begin
        dwell_d = dwell_q + 1'b1;
        if (dwell_q == HOLD_LAST) state_d = S_ISO_SET;
      end
      S_ISO_SET: begin
        dwell_d = dwell_q + 1'b1;
        if (dwell_q == HOLD_LAST) state_d = S_PWR_DN;
      end
      S_PWR_DN: begin
        tmo_d = tmo_q + 1'b1;
        if (!pgood_s_q)             state_d = S_OFF;
        else if (tmo_q == TMO_LAST) state_d = S_FLT;
      end
      S_FLT: begin
        if (!REQ_ON && !pgood_s_q) state_d = S_OFF;
      end
      default: state_d = S_OFF;
    endcase
    if (state_d != state_q) begin
      dwell_d = '0;
      tmo_d   = '0;
    end
  end

  // Moore decode of the state register only; the default is the safe isolated-and-off pattern.
  always_comb begin
    PSW_EN = 1'b0;
    ISO_EN = 1'b1;
    DRV_EN = 1'b0;
    ACK    = 1'b0;
    BUSY   = 1'b0;
    FAULT  = 1'b0;
    case (state_q)
      S_PWR_UP:  begin PSW_EN = 1'b1; BUSY = 1'b1; end
      S_ISO_REL: begin PSW_EN = 1'b1; ISO_EN = 1'b0; BUSY = 1'b1; end
      S_ON:      begin PSW_EN = 1'b1; ISO_EN = 1'b0; DRV_EN = 1'b1; ACK = 1'b1; end
      S_DRV_OFF: begin PSW_EN = 1'b1; ISO_EN = 1'b0; BUSY = 1'b1; end
      S_ISO_SET: begin PSW_EN = 1'b1; BUSY = 1'b1; end
      S_PWR_DN:  begin BUSY = 1'b1; end
      S_FLT:     begin FAULT = 1'b1; end
      default:   begin end
    endcase
  end

endmodule

// File: tb/tb_gf180mcu_fd_io__seg_pwr_seq.sv
// Self-checking bench for the segment power sequencer: directed plan steps plus a randomized
// run, all compared against a phase/age behavioural model of the sequencing rules.
module tb_gf180mcu_fd_io__seg_pwr_seq;

  localparam int SETTLE = 4;
  localparam int HOLD   = 2;
  localparam int TMO    = 16;

  localparam int P_OFF = 0, P_UP = 1, P_REL = 2, P_ON = 3, P_DOFF = 4, P_ISET = 5, P_DN = 6, P_FLT = 7;

  logic CLK = 1'b0;
  logic RST, REQ_ON, PGOOD;
  logic PSW_EN, ISO_EN, DRV_EN, ACK, BUSY, FAULT;
  logic [5:0] dut_outs;

  int n_cmp  = 0;
  int n_fail = 0;

  int m_phase = P_OFF;
  int m_age   = 0;
  int m_run   = 0;
  bit m_meta  = 1'b0;
  bit m_s     = 1'b0;

  gf180mcu_fd_io__seg_pwr_seq #(
    .SETTLE_CYCLES(SETTLE), .ISO_HOLD(HOLD), .TIMEOUT(TMO), .CNT_W(5)
  ) dut (
    .CLK(CLK), .RST(RST), .REQ_ON(REQ_ON), .PGOOD(PGOOD),
    .PSW_EN(PSW_EN), .ISO_EN(ISO_EN), .DRV_EN(DRV_EN),
    .ACK(ACK), .BUSY(BUSY), .FAULT(FAULT)
  );

  assign dut_outs = {PSW_EN, ISO_EN, DRV_EN, ACK, BUSY, FAULT};

  always #5 CLK = ~CLK;

  // Output table per phase, ordered {PSW, ISO, DRV, ACK, BUSY, FAULT}.
  function automatic logic [5:0] m_outs(input int p);
    case (p)
      P_UP:    return 6'b110010;
      P_REL:   return 6'b100010;
      P_ON:    return 6'b101100;
      P_DOFF:  return 6'b100010;
      P_ISET:  return 6'b110010;
      P_DN:    return 6'b010010;
      P_FLT:   return 6'b010001;
      default: return 6'b010000;
    endcase
  endfunction

  // One clock edge of the reference: m_age is edges already spent in the phase, m_run the
  // current run of good synchronised PGOOD samples, m_meta/m_s the two-stage sync pipe.
  task automatic model_edge();
    int nxt;
    if (RST) begin
      m_phase = P_OFF; m_age = 0; m_run = 0; m_meta = 1'b0; m_s = 1'b0;
      return;
    end
    nxt = m_phase;
    case (m_phase)
      P_OFF:  if (REQ_ON) nxt = P_UP;
      P_UP: begin
        if (!REQ_ON)                      nxt = P_DN;
        else if (m_s && m_run + 1 >= SETTLE) nxt = P_REL;
        else if (m_age + 1 >= TMO)        nxt = P_FLT;
      end
      P_REL: begin
        if (!REQ_ON)                nxt = P_ISET;
        else if (m_age + 1 >= HOLD) nxt = P_ON;
      end
      P_ON: begin
        if (!m_s)         nxt = P_FLT;
        else if (!REQ_ON) nxt = P_DOFF;
      end
      P_DOFF: if (m_age + 1 >= HOLD) nxt = P_ISET;
      P_ISET: if (m_age + 1 >= HOLD) nxt = P_DN;
      P_DN: begin
        if (!m_s)                  nxt = P_OFF;
        else if (m_age + 1 >= TMO) nxt = P_FLT;
      end
      P_FLT: if (!REQ_ON && !m_s) nxt = P_OFF;
      default: nxt = P_OFF;
    endcase
    if (nxt != m_phase) begin
      m_age = 0; m_run = 0;
    end else begin
      m_age = m_age + 1;
      m_run = m_s ? m_run + 1 : 0;
    end
    m_phase = nxt;
    m_s     = m_meta;
    m_meta  = PGOOD;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    int hot;
    @(posedge CLK);
    model_edge();
    #1;
    hot = int'(ACK) + int'(BUSY) + int'(FAULT);
    check("model_outs", dut_outs, m_outs(m_phase));
    check("inv_drv_needs_iso_off_psw_on", !DRV_EN || (!ISO_EN && PSW_EN), 1'b1);
    check("inv_iso_off_needs_psw_on", ISO_EN || PSW_EN, 1'b1);
    check("inv_ack_busy_fault_onehot", hot <= 1, 1'b1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_ack(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (ACK) break;
    end
    check(tag, ACK, 1'b1);
  endtask

  initial begin
    RST = 1'b1; REQ_ON = 1'b0; PGOOD = 1'b1;
    ticks(2);
    check("reset_values", dut_outs, 6'b010000);
    RST = 1'b0;
    ticks(3);

    // Nominal power-up with PGOOD already settled.
    REQ_ON = 1'b1;
    tick();
    check("up_psw_e0", PSW_EN, 1'b1);
    check("up_iso_e0", ISO_EN, 1'b1);
    ticks(3);
    check("up_iso_e3", ISO_EN, 1'b1);
    tick();
    check("up_iso_e4", ISO_EN, 1'b0);
    tick();
    check("up_ack_e5", ACK, 1'b0);
    tick();
    check("up_drv_ack_e6", {DRV_EN, ACK}, 2'b11);

    // Nominal power-down.
    REQ_ON = 1'b0;
    tick();
    check("dn_drv_f0", DRV_EN, 1'b0);
    check("dn_iso_f0", ISO_EN, 1'b0);
    ticks(2);
    check("dn_iso_f2", {PSW_EN, ISO_EN}, 2'b11);
    ticks(2);
    check("dn_psw_f4", {PSW_EN, BUSY}, 2'b01);
    PGOOD = 1'b0;
    ticks(2);
    check("dn_busy_f6", BUSY, 1'b1);
    tick();
    check("dn_off_f7", dut_outs, 6'b010000);

    // PGOOD glitch during settle restarts the settle count.
    REQ_ON = 1'b1; PGOOD = 1'b1;
    ticks(3);
    PGOOD = 1'b0;
    tick();
    PGOOD = 1'b1;
    ticks(5);
    check("glitch_iso_still_set_e8", ISO_EN, 1'b1);
    tick();
    check("glitch_iso_released_e9", ISO_EN, 1'b0);

    // Timeout in PWR_UP with PGOOD held low.
    RST = 1'b1;
    tick();
    RST = 1'b0; REQ_ON = 1'b1; PGOOD = 1'b0;
    tick();
    check("tmo_in_pwr_up", dut_outs, 6'b110010);
    ticks(TMO - 1);
    check("tmo_not_yet", FAULT, 1'b0);
    tick();
    check("tmo_fault", dut_outs, 6'b010001);
    tick();
    check("flt_held_while_req", FAULT, 1'b1);
    REQ_ON = 1'b0;
    tick();
    check("flt_exit_off", dut_outs, 6'b010000);

    // Brown-out while ON.
    PGOOD = 1'b1; REQ_ON = 1'b1;
    wait_ack("brownout_reach_on", 40);
    PGOOD = 1'b0;
    ticks(2);
    check("brownout_still_on", ACK, 1'b1);
    tick();
    check("brownout_flt", dut_outs, 6'b010001);
    REQ_ON = 1'b0;
    tick();
    check("brownout_clear", FAULT, 1'b0);

    // Abort during ISO_REL, then re-request during power-down.
    PGOOD = 1'b1; REQ_ON = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!ISO_EN) break;
    end
    check("abort_reach_iso_rel", {ISO_EN, DRV_EN}, 2'b00);
    REQ_ON = 1'b0;
    tick();
    check("abort_iso_set", {ISO_EN, DRV_EN, BUSY}, 3'b101);
    REQ_ON = 1'b1;
    tick();
    check("abort_iso_set_hold", {PSW_EN, ISO_EN, DRV_EN}, 3'b110);
    tick();
    check("abort_pwr_dn_despite_req", {PSW_EN, BUSY}, 2'b01);
    PGOOD = 1'b0;
    ticks(2);
    check("abort_pwr_dn_wait", BUSY, 1'b1);
    tick();
    check("abort_off_first", dut_outs, 6'b010000);
    tick();
    check("abort_reup_next_edge", dut_outs, 6'b110010);

    // Reset while ON.
    PGOOD = 1'b1;
    wait_ack("rst_reach_on", 40);
    RST = 1'b1;
    tick();
    check("rst_in_on", dut_outs, 6'b010000);
    RST = 1'b0; REQ_ON = 1'b0;
    ticks(2);

    // Randomized run; PGOOD mostly tracks the modelled switch so full sequences occur.
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] mo;
      mo = m_outs(m_phase);
      if ($urandom_range(0, 29) == 0) REQ_ON = ~REQ_ON;
      if ($urandom_range(0, 9) == 0) PGOOD = 1'($urandom_range(0, 1));
      else                           PGOOD = mo[5];
      RST = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_io__seg_pwr_seq.md
Name: gf180mcu_fd_io__seg_pwr_seq

Overview:
- Sequences power, isolation and driver enable for one pad-ring segment on the far side of a ring break cell.
- Power-up order: switch on the segment supply, wait for a settled PGOOD, release isolation, enable pad drivers.
- Power-down runs the same steps in reverse.
- Sits in the always-on core domain, adjacent to the break; drives the segment's power switch, isolation clamps and driver-enable rail.

Parameters:
- SETTLE_CYCLES, 64: consecutive cycles of synced PGOOD high required before isolation release; range 1..2^CNT_W-1.
- ISO_HOLD, 8: dwell cycles in each isolation/driver step; >=1.
- TIMEOUT, 1024: maximum cycles allowed in PWR_UP or PWR_DN before FAULT; must exceed SETTLE_CYCLES.
- CNT_W, 11: width of the dwell and timeout counters; must hold TIMEOUT.

Ports:
- CLK  input  1  Sequencer clock.
- RST  input  1  Synchronous, active-high reset.
- REQ_ON  input  1  Level request; 1 = segment powered, 0 = segment off. Synchronous to CLK.
- PGOOD  input  1  Segment supply monitor; asynchronous; 2-flop synchronised internally to PGOOD_s.
- PSW_EN  output  1  Segment power switch enable.
- ISO_EN  output  1  Isolation clamp enable; 1 = isolated.
- DRV_EN  output  1  Pad driver enable.
- ACK  output  1  Segment fully on (state ON).
- BUSY  output  1  In a transitional state.
- FAULT  output  1  Sequencing fault latched.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - PSW_EN=0, ISO_EN=1, DRV_EN=0, ACK=0, BUSY=0, FAULT=0.
  - State OFF; counters 0; synchroniser flops 0.
  - RST asserted mid-sequence forces these values on the next edge, from any state.
- Output decoding:
  - All outputs are Moore and decoded from registered state, with no combinational path from inputs.
  - Every state transition clears the dwell and timeout counters.
- States and outputs (PSW/ISO/DRV/ACK/BUSY/FAULT):
  - OFF 0/1/0/0/0/0
  - PWR_UP 1/1/0/0/1/0
  - ISO_REL 1/0/0/0/1/0
  - ON 1/0/1/1/0/0
  - DRV_OFF 1/0/0/0/1/0
  - ISO_SET 1/1/0/0/1/0
  - PWR_DN 0/1/0/0/1/0
  - FLT 0/1/0/0/0/1
- Transitions from OFF and PWR_UP:
  - OFF: REQ_ON=1 -> PWR_UP.
  - PWR_UP, settle counting: each cycle with PGOOD_s=1 increments the dwell counter; PGOOD_s=0 clears it.
  - PWR_UP, exit on settle: dwell==SETTLE_CYCLES-1 with PGOOD_s=1 -> ISO_REL.
  - PWR_UP, abort: REQ_ON=0 -> PWR_DN (isolation never released).
  - PWR_UP, timeout: timeout counter reaches TIMEOUT-1 -> FLT.
  - Priority in PWR_UP: abort > settle-complete > timeout.
- Transitions from ISO_REL and ON:
  - ISO_REL: REQ_ON=0 -> ISO_SET; else after ISO_HOLD cycles -> ON.
  - ON: PGOOD_s=0 -> FLT (takes priority over REQ_ON=0).
  - ON: REQ_ON=0 -> DRV_OFF.
- Transitions on the power-down path:
  - DRV_OFF: after ISO_HOLD cycles -> ISO_SET.
  - ISO_SET: after ISO_HOLD cycles -> PWR_DN.
  - REQ_ON is ignored in DRV_OFF and ISO_SET; a power-down always completes.
  - PWR_DN: PGOOD_s=0 -> OFF; timeout counter reaches TIMEOUT-1 -> FLT; PGOOD_s=0 wins when both occur.
  - REQ_ON=1 arriving during power-down takes effect only once OFF is reached (re-sampled in OFF).
- FLT:
  - Outputs go to the safe state immediately (registered).
  - Exits to OFF only when REQ_ON=0 and PGOOD_s=0 in the same cycle; FAULT clears on that transition.
- Latency, with PGOOD_s already high:
  - Up: ACK rises SETTLE_CYCLES+ISO_HOLD cycles after the edge that samples REQ_ON=1.
  - Down: PSW_EN falls 2*ISO_HOLD cycles after the edge that samples REQ_ON=0.
- Ordering invariants, checked by assertions:
  - DRV_EN=1 implies ISO_EN=0 and PSW_EN=1.
  - ISO_EN=0 implies PSW_EN=1.
  - At most one of ACK, BUSY, FAULT is high.

Test Plan:
- Bench parameters: SETTLE_CYCLES=4, ISO_HOLD=2, TIMEOUT=16.
- Nominal up: PGOOD high from time 0, reset, REQ_ON=1 sampled at edge e0 -> PSW_EN=1 after e0, ISO_EN=0 after e4, DRV_EN=ACK=1 after e6.
- Nominal down: from ON, REQ_ON=0 sampled at f0 -> DRV_EN=0 after f0, ISO_EN=1 after f2, PSW_EN=0 after f4; drop PGOOD at f5 -> OFF, BUSY=0 after f7.
- Glitch and timeout: in PWR_UP, pulse PGOOD low 1 cycle after 3 good cycles -> settle restarts, ISO_REL reached 4 PGOOD_s-high cycles later; hold PGOOD low -> FLT, FAULT=1 after 16 cycles in PWR_UP.
- Brown-out in ON: PGOOD falls -> FLT two edges later with PSW_EN=0, ISO_EN=1, DRV_EN=0; REQ_ON=0 -> OFF and FAULT=0 next cycle.
- Abort and re-request: REQ_ON=0 during ISO_REL -> ISO_SET with ISO_EN=1 and DRV_EN never set; REQ_ON=1 during ISO_SET -> sequence reaches OFF first, then PWR_UP on the following edge.
- Reset mid-sequence: RST=1 in ON -> next edge gives all reset values with ISO_EN=1; ordering assertions hold in every cycle.
